// File: rtl/des_key_sched.sv
// DES key schedule sequencer: PC-1 on the latched key, then 16 rounds of
// C/D rotation, with one PC-2 subkey issued per round over valid/ready.

// PC-1 permutation: output bit 55 holds PC-1 entry 1, key[i] = FIPS bit i.
module pcone (
  input  logic [63:0] i_key,
  output logic [55:0] o_cd
);
  // Parity bits (FIPS 8,16,...,64) take no part in the schedule.
  logic w_unused_parity;
  assign w_unused_parity = ^{i_key[0], i_key[8], i_key[16], i_key[24],
                             i_key[32], i_key[40], i_key[48], i_key[56]};

  assign o_cd = {i_key[57], i_key[49], i_key[41], i_key[33], i_key[25], i_key[17], i_key[9],
                 i_key[1],  i_key[58], i_key[50], i_key[42], i_key[34], i_key[26], i_key[18],
                 i_key[10], i_key[2],  i_key[59], i_key[51], i_key[43], i_key[35], i_key[27],
                 i_key[19], i_key[11], i_key[3],  i_key[60], i_key[52], i_key[44], i_key[36],
                 i_key[63], i_key[55], i_key[47], i_key[39], i_key[31], i_key[23], i_key[15],
                 i_key[7],  i_key[62], i_key[54], i_key[46], i_key[38], i_key[30], i_key[22],
                 i_key[14], i_key[6],  i_key[61], i_key[53], i_key[45], i_key[37], i_key[29],
                 i_key[21], i_key[13], i_key[5],  i_key[28], i_key[20], i_key[12], i_key[4]};
endmodule

module des_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FIN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [55:0] r_cd;
  logic [3:0]  r_round;
  logic        r_dir;
  logic [55:0] w_pc1;

  pcone u_pcone (
    .i_key (key),
    .o_cd  (w_pc1)
  );

  // Per-round rotation amount; decrypt starts at K16 which needs no rotation.
  function automatic logic [1:0] shift_amt(input logic [3:0] r, input logic d);
    if (r == 4'd0)
      return d ? 2'd0 : 2'd1;
    else if (r == 4'd1 || r == 4'd8 || r == 4'd15)
      return 2'd1;
    else
      return 2'd2;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] h, input logic [1:0] n,
                                        input logic d);
    case ({d, n})
      3'b001:  return {h[26:0], h[27]};
      3'b010:  return {h[25:0], h[27:26]};
      3'b101:  return {h[0], h[27:1]};
      3'b110:  return {h[1:0], h[27:2]};
      default: return h;
    endcase
  endfunction

  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic [1:0] n,
                                         input logic d);
    return {rot28(cd[55:28], n, d), rot28(cd[27:0], n, d)};
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and status outputs decoded from the state register.
  always_comb begin
    w_next       = r_state;
    subkey_valid = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        subkey_valid = 1'b1;
        if (subkey_ready && r_round == 4'd15) w_next = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // C/D halves, round counter and direction; advance only on an accepted subkey.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cd    <= '0;
      r_round <= '0;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dir   <= decrypt;
            r_cd    <= rot_cd(w_pc1, shift_amt(4'd0, decrypt), decrypt);
            r_round <= '0;
          end
        end
        S_ISSUE: begin
          if (subkey_ready && r_round != 4'd15) begin
            r_cd    <= rot_cd(r_cd, shift_amt(r_round + 4'd1, r_dir), r_dir);
            r_round <= r_round + 4'd1;
          end
        end
        S_FIN:   r_round <= '0;
        default: r_round <= '0;
      endcase
    end
  end

  assign round = r_round;

  // PC-2: entry n selects cd[56-n]; subkey[47] is entry 1.
  assign subkey = {r_cd[56-14], r_cd[56-17], r_cd[56-11], r_cd[56-24], r_cd[56-1],  r_cd[56-5],
                   r_cd[56-3],  r_cd[56-28], r_cd[56-15], r_cd[56-6],  r_cd[56-21], r_cd[56-10],
                   r_cd[56-23], r_cd[56-19], r_cd[56-12], r_cd[56-4],  r_cd[56-26], r_cd[56-8],
                   r_cd[56-16], r_cd[56-7],  r_cd[56-27], r_cd[56-20], r_cd[56-13], r_cd[56-2],
                   r_cd[56-41], r_cd[56-52], r_cd[56-31], r_cd[56-37], r_cd[56-47], r_cd[56-55],
                   r_cd[56-30], r_cd[56-40], r_cd[56-51], r_cd[56-45], r_cd[56-33], r_cd[56-48],
                   r_cd[56-44], r_cd[56-49], r_cd[56-39], r_cd[56-56], r_cd[56-34], r_cd[56-53],
                   r_cd[56-46], r_cd[56-42], r_cd[56-50], r_cd[56-36], r_cd[56-29], r_cd[56-32]};
endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched: expected subkeys are queued before each
// schedule starts and a negedge monitor checks every presented subkey.
module tb_des_key_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [63:0] key = '0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready = 1'b0;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  des_key_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  r;
    logic [47:0] k;
  } exp_t;

  exp_t        sb_q[$];
  logic [47:0] enc_tab[16];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          valid_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Conventional FIPS hex (bit 1 = MSB) into the port layout key[i] = FIPS bit i.
  function automatic logic [63:0] fips2key(input logic [63:0] k);
    logic [63:0] r;
    r[0] = k[0];
    for (int i = 1; i < 64; i++) r[i] = k[64-i];
    return r;
  endfunction

  // Monitor: every presented subkey must match the scoreboard head.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (subkey_valid) begin
      valid_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_subkey actual=%h round=%0d expected=none", subkey, round);
      end else begin
        chk("subkey", {16'h0, subkey}, {16'h0, sb_q[0].k});
        chk("round", {60'h0, round}, {60'h0, sb_q[0].r});
        if (subkey_ready) void'(sb_q.pop_front());
      end
    end
  end

  // src: 0 FIPS encrypt, 1 FIPS decrypt, 2 all zero, 3 all ones
  // mode: 0 ready=1, 1 random ready + stall at round 3, 2 start at round 7, 3 reset at round 9
  task automatic run(input logic [63:0] k, input logic dec, input int src, input int mode);
    int   stall_left = 0;
    logic stalled = 1'b0;
    logic injected = 1'b0;
    logic aborted = 1'b0;
    exp_t e;
    for (int r = 0; r < 16; r++) begin
      e.r = 4'(r);
      case (src)
        0:       e.k = enc_tab[r];
        1:       e.k = enc_tab[15-r];
        2:       e.k = '0;
        default: e.k = '1;
      endcase
      sb_q.push_back(e);
    end
    done_cnt  = 0;
    valid_cnt = 0;
    key       = k;
    decrypt   = dec;
    start     = 1'b1;
    subkey_ready = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    key     = ~k;
    decrypt = ~dec;
    for (int c = 0; c < 200 && busy; c++) begin
      start = 1'b0;
      subkey_ready = 1'b1;
      if (mode == 1) begin
        if (!stalled && subkey_valid && round == 4'd3) begin
          stalled = 1'b1;
          stall_left = 5;
        end
        if (stall_left > 0) begin
          subkey_ready = 1'b0;
          stall_left--;
        end else begin
          subkey_ready = 1'($urandom_range(0, 1));
        end
      end
      if (mode == 2 && !injected && round == 4'd7) begin
        injected = 1'b1;
        start    = 1'b1;
        key      = 64'h0123456789ABCDEF;
        decrypt  = 1'b1;
      end
      if (mode == 3 && round == 4'd9) begin
        rst = 1'b1;
        #1;
        chk("rst_valid", {63'h0, subkey_valid}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_round", {60'h0, round}, 64'h0);
        chk("rst_subkey", {16'h0, subkey}, 64'h0);
        sb_q.delete();
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    subkey_ready = 1'b0;
    if (aborted) begin
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_idle", {63'h0, busy}, 64'h0);
    end else begin
      chk("finish_in_time", {63'h0, busy}, 64'h0);
      chk("queue_drained", 64'(sb_q.size()), 64'd0);
      chk("done_pulses", 64'(done_cnt), 64'd1);
      if (mode == 0 || mode == 2) chk("valid_cycles", 64'(valid_cnt), 64'd16);
    end
    sb_q.delete();
  endtask

  initial begin
    logic [63:0] fk;
    logic [63:0] par;
    enc_tab[0]  = 48'h1B02EFFC7072; enc_tab[1]  = 48'h79AED9DBC9E5;
    enc_tab[2]  = 48'h55FC8A42CF99; enc_tab[3]  = 48'h72ADD6DB351D;
    enc_tab[4]  = 48'h7CEC07EB53A8; enc_tab[5]  = 48'h63A53E507B2F;
    enc_tab[6]  = 48'hEC84B7F618BC; enc_tab[7]  = 48'hF78A3AC13BFB;
    enc_tab[8]  = 48'hE0DBEBEDE781; enc_tab[9]  = 48'hB1F347BA464F;
    enc_tab[10] = 48'h215FD3DED386; enc_tab[11] = 48'h7571F59467E9;
    enc_tab[12] = 48'h97C5D1FABA41; enc_tab[13] = 48'h5F43B7F2E73A;
    enc_tab[14] = 48'hBF918D3D3F0A; enc_tab[15] = 48'hCB3D8B0E17F5;
    fk = fips2key(64'h133457799BBCDFF1);

    #1;
    chk("reset_valid", {63'h0, subkey_valid}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_round", {60'h0, round}, 64'h0);
    chk("reset_subkey", {16'h0, subkey}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run(fk, 1'b0, 0, 0);
    run(fk, 1'b1, 1, 0);
    run(fk, 1'b0, 0, 1);
    run(fk, 1'b0, 0, 2);
    run(fk, 1'b0, 0, 3);
    run(fk, 1'b0, 0, 0);
    run(64'h0, 1'b0, 2, 0);
    run('1, 1'b0, 3, 0);
    par = '1;
    for (int i = 0; i < 64; i += 8) par[i] = 1'b0;
    run(par, 1'b0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
